// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h8B1F_03FF;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] pc_bl;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic if_id_t make_bubble(input logic [31:0] nop);
        if_id_t b;
        b.pc    = 64'd0;
        b.pc_bl = 64'd0;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fullAdder64.sv
// 64-bit adder with carry-in; the carry-out is dropped so sums wrap modulo 2^64.
module fullAdder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum
);
    assign sum = a + b + {63'd0, cin};
endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds when disabled, loads on enable, flush forces a bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_en,
    input  logic   i_flush,
    input  if_id_t i_data,
    output if_id_t o_data
);
    if_id_t r_data;

    // Register update; flush wins over enable so a redirect never leaks the wrong-path fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= make_bubble(NOP);
        end else if (i_flush) begin
            r_data <= make_bubble(NOP);
        end else if (i_en) begin
            r_data <= i_data;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_data = r_data;
endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, redirect/stall handling, misaligned-target fault and squash counter.
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_ID_en,
    input  logic        BrTaken,
    input  logic [63:0] BrTakenAddr,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [63:0] PC_Addr_out,
    output logic [63:0] PC_BL_out,
    output logic [31:0] instruction_out,
    output logic        valid_out,
    output logic        fetch_fault,
    output logic [31:0] squash_count
);
    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [63:0]  r_pc;
    logic [63:0]  w_pc_next;
    logic [63:0]  w_pc_plus4;
    logic         r_fault;
    logic         w_fault_next;
    logic [31:0]  r_squash;
    logic [31:0]  w_squash_next;
    logic         w_load;
    logic         w_flush;
    if_id_t       w_fetch;
    if_id_t       w_if_id;

    fullAdder64 u_pc_inc (
        .a   (r_pc),
        .b   (64'd4),
        .cin (1'b0),
        .sum (w_pc_plus4)
    );

    assign w_fetch = '{pc: r_pc, pc_bl: w_pc_plus4, instr: imem_instr, valid: 1'b1};

    // Next-state decode; a stalled cycle ignores BrTaken because decode keeps it asserted
    always_comb begin
        w_next_state  = r_state;
        w_pc_next     = r_pc;
        w_fault_next  = r_fault;
        w_squash_next = r_squash;
        w_load        = 1'b0;
        w_flush       = 1'b0;
        case (r_state)
            RUN: begin
                if (IF_ID_en) begin
                    if (BrTaken) begin
                        w_flush = 1'b1;
                        if (BrTakenAddr[1:0] == 2'b00) begin
                            w_pc_next     = BrTakenAddr;
                            w_squash_next = r_squash + 32'd1;
                        end else begin
                            w_next_state = FAULT;
                            w_fault_next = 1'b1;
                        end
                    end else begin
                        w_load    = 1'b1;
                        w_pc_next = w_pc_plus4;
                    end
                end else begin
                    w_load = 1'b0;
                end
            end
            FAULT: begin
                w_flush = 1'b1;
            end
            default: begin
                w_next_state = FAULT;
                w_fault_next = 1'b1;
                w_flush      = 1'b1;
            end
        endcase
    end

    // State, PC, fault flag and squash counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_pc     <= RESET_PC;
            r_fault  <= 1'b0;
            r_squash <= 32'd0;
        end else begin
            r_state  <= w_next_state;
            r_pc     <= w_pc_next;
            r_fault  <= w_fault_next;
            r_squash <= w_squash_next;
        end
    end

    if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_load),
        .i_flush (w_flush),
        .i_data  (w_fetch),
        .o_data  (w_if_id)
    );

    assign imem_addr       = r_pc;
    assign PC_Addr_out     = w_if_id.pc;
    assign PC_BL_out       = w_if_id.pc_bl;
    assign instruction_out = w_if_id.instr;
    assign valid_out       = w_if_id.valid;
    assign fetch_fault     = r_fault;
    assign squash_count    = r_squash;
endmodule
